// File: rtl/dbscan_core_detect.sv
// dbscan_core_detect
//   Core-point detection stage for DBSCAN. On start it visits every point
//   pair (i, j) through the point memory's two combinational read ports.
//   For each point i it counts the neighbours within squared radius EPS_SQ.
//   The self pair counts as a neighbour. It writes one core flag per point
//   and then pulses done so that cluster expansion can begin.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   start                one-cycle request, honoured only in IDLE
//   busy                 high from the cycle after start until done
//   done                 one-cycle pulse after all N flags are written
//   raddr_i, raddr_j     read addresses (point under test, candidate)
//   xi..zi, xj..zj       coordinates returned for raddr_i / raddr_j
//   we_core, waddr, wcore core-flag write port (waddr always equals i)
//   n_core               number of core points, valid from done onward
//
// Build option
//   DBSCAN_PIPE_DIST_EN  registers the squared distance before the
//                        compare. This adds one drain cycle per point.
//                        The results are identical.

module dbscan_core_detect #(
  parameter  int N       = 16,
  parameter  int EPS_SQ  = 400,
  parameter  int MIN_PTS = 4,
  localparam int AW      = (N > 1) ? $clog2(N) : 1,
  localparam int CW      = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr_i,
  output logic [AW-1:0] raddr_j,
  input  logic [7:0]    xi,
  input  logic [7:0]    yi,
  input  logic [7:0]    zi,
  input  logic [7:0]    xj,
  input  logic [7:0]    yj,
  input  logic [7:0]    zj,
  output logic          we_core,
  output logic [AW-1:0] waddr,
  output logic          wcore,
  output logic [CW-1:0] n_core
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [17:0]   EPS_C    = 18'(EPS_SQ);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_PTS);

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [15:0] sq16(input logic [7:0] a);
    return {8'h00, a} * {8'h00, a};
  endfunction

  logic [2:0]    state_r, state_s;
  logic [AW-1:0] i_r, i_s, j_r, j_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_acc_s;
  logic [CW-1:0] ncore_r, ncore_s;
  logic          busy_r, busy_s, done_r, done_s, we_r, we_s, wcore_r, wcore_s;
  logic [17:0]   dist_s;
  logic          hit_s;

  // Squared Euclidean distance of the current pair (max 195075, so it cannot wrap).
  always_comb begin
    dist_s = {2'b00, sq16(abs_diff(xi, xj))}
           + {2'b00, sq16(abs_diff(yi, yj))}
           + {2'b00, sq16(abs_diff(zi, zj))};
  end

`ifdef DBSCAN_PIPE_DIST_EN
  logic [17:0] dist_r;
  logic        pv_r;

  // Distance pipeline register; pv_r marks a stage that holds a real scanned pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_r <= 18'd0;
      pv_r   <= 1'b0;
    end else begin
      dist_r <= dist_s;
      pv_r   <= (state_r == S_SCAN);
    end
  end

  assign hit_s = pv_r && (dist_r <= EPS_C);
`else
  assign hit_s = (state_r == S_SCAN) && (dist_s <= EPS_C);
`endif

  assign cnt_acc_s = cnt_r + {{(CW-1){1'b0}}, hit_s};

  // Next-state logic: scan all j for each i, then write that point's core flag.
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    cnt_s   = cnt_r;
    ncore_s = ncore_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    we_s    = 1'b0;
    wcore_s = wcore_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_SCAN;
          i_s     = '0;
          j_s     = '0;
          cnt_s   = '0;
          ncore_s = '0;
          busy_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SCAN: begin
        cnt_s = cnt_acc_s;
        if (j_r == LAST_IDX) begin
`ifdef DBSCAN_PIPE_DIST_EN
          // The last pair is still in the pipeline, so raddr_j holds N-1 for one more cycle.
          state_s = S_DRAIN;
`else
          state_s = S_WRITE;
          we_s    = 1'b1;
          wcore_s = (cnt_acc_s >= MIN_C);
`endif
        end else begin
          j_s = j_r + 1'b1;
        end
      end
      S_DRAIN: begin
        cnt_s   = cnt_acc_s;
        state_s = S_WRITE;
        we_s    = 1'b1;
        wcore_s = (cnt_acc_s >= MIN_C);
      end
      S_WRITE: begin
        ncore_s = ncore_r + {{(CW-1){1'b0}}, wcore_r};
        if (i_r == LAST_IDX) begin
          state_s = S_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = S_SCAN;
          i_s     = i_r + 1'b1;
          j_s     = '0;
          cnt_s   = '0;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any scan and discards partial results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      i_r     <= '0;
      j_r     <= '0;
      cnt_r   <= '0;
      ncore_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      we_r    <= 1'b0;
      wcore_r <= 1'b0;
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      j_r     <= j_s;
      cnt_r   <= cnt_s;
      ncore_r <= ncore_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      we_r    <= we_s;
      wcore_r <= wcore_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign raddr_i = i_r;
  assign raddr_j = j_r;
  assign waddr   = i_r;
  assign we_core = we_r;
  assign wcore   = wcore_r;
  assign n_core  = ncore_r;

endmodule

// File: tb/tb_dbscan_core_detect.sv
// Directed bench: six parameterisations of the core detector run side by side
// on one shared point memory, with hand-computed core masks per data set.
module tb_dbscan_core_detect;

  localparam int NC = 6;
  localparam int N  = 16;
`ifdef DBSCAN_PIPE_DIST_EN
  localparam int LAT = N * (N + 2);
`else
  localparam int LAT = N * (N + 1);
`endif

  logic clk = 1'b0;
  logic rst, start, mon_clr;
  always #5 clk = ~clk;

  logic [7:0]    mx[N], my[N], mz[N];
  logic [NC-1:0] busy, done, we_core, wcore;
  logic [3:0]    raddr_i[NC], raddr_j[NC], waddr[NC];
  logic [7:0]    xi[NC], yi[NC], zi[NC], xj[NC], yj[NC], zj[NC];
  logic [4:0]    n_core[NC];

  // configs: 0 eps400/min4, 1 eps400/min2, 2 eps400/min1, 3 eps399/min2,
  //          4 eps195075/min2, 5 eps195075/min16
  function automatic int eps_of(int g);
    case (g)
      3: return 399;
      4, 5: return 195075;
      default: return 400;
    endcase
  endfunction

  function automatic int min_of(int g);
    case (g)
      0: return 4;
      1, 3, 4: return 2;
      2: return 1;
      default: return 16;
    endcase
  endfunction

  genvar g;
  generate
    for (g = 0; g < NC; g++) begin : g_dut
      assign xi[g] = mx[raddr_i[g]];
      assign yi[g] = my[raddr_i[g]];
      assign zi[g] = mz[raddr_i[g]];
      assign xj[g] = mx[raddr_j[g]];
      assign yj[g] = my[raddr_j[g]];
      assign zj[g] = mz[raddr_j[g]];
      dbscan_core_detect #(.N(N), .EPS_SQ(eps_of(g)), .MIN_PTS(min_of(g))) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy[g]), .done(done[g]),
        .raddr_i(raddr_i[g]), .raddr_j(raddr_j[g]),
        .xi(xi[g]), .yi(yi[g]), .zi(zi[g]),
        .xj(xj[g]), .yj(yj[g]), .zj(zj[g]),
        .we_core(we_core[g]), .waddr(waddr[g]), .wcore(wcore[g]),
        .n_core(n_core[g])
      );
    end
  endgenerate

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // write monitor: collects flags, checks address order and non-consecutive writes
  logic [15:0]   got_mask[NC];
  int            wr_cnt[NC];
  int            order_err[NC];
  logic [NC-1:0] prev_we = '0;
  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (mon_clr) begin
        got_mask[k]  <= 16'h0000;
        wr_cnt[k]    <= 0;
        order_err[k] <= 0;
      end else if (we_core[k]) begin
        got_mask[k][waddr[k]] <= wcore[k];
        wr_cnt[k]    <= wr_cnt[k] + 1;
        order_err[k] <= order_err[k] + ((32'(waddr[k]) != wr_cnt[k]) ? 1 : 0)
                                     + (prev_we[k] ? 1 : 0);
      end
    end
    prev_we <= we_core;
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int d);
    for (int i = 0; i < N; i++) begin
      case (d)
        0: begin mx[i] = 8'd10; my[i] = 8'd10; mz[i] = 8'd10; end
        1: begin
          if (i < 6) begin mx[i] = 8'(50 * i); my[i] = 8'd0; mz[i] = 8'd0; end
          else begin mx[i] = 8'd255; my[i] = 8'd255; mz[i] = 8'd255; end
        end
        2: begin
          if (i == 0) begin mx[i] = 8'd0; my[i] = 8'd0; mz[i] = 8'd0; end
          else if (i == 1) begin mx[i] = 8'd20; my[i] = 8'd0; mz[i] = 8'd0; end
          else begin mx[i] = 8'd200; my[i] = 8'd200; mz[i] = 8'd200; end
        end
        default: begin
          if (i == 0) begin mx[i] = 8'd0; my[i] = 8'd0; mz[i] = 8'd0; end
          else if (i == 1) begin mx[i] = 8'd255; my[i] = 8'd255; mz[i] = 8'd255; end
          else begin mx[i] = 8'd128; my[i] = 8'd128; mz[i] = 8'd128; end
        end
      endcase
    end
  endtask

  // hand-computed core masks (bit p = core flag of point p)
  function automatic logic [15:0] exp_mask(int d, int k);
    case (d)
      0: return 16'hFFFF;
      1: return (k == 0 || k == 1 || k == 3) ? 16'hFFC0 : 16'hFFFF;
      2: return (k == 0 || k == 3) ? 16'hFFFC : 16'hFFFF;
      default: return (k == 0 || k == 1 || k == 3) ? 16'hFFFC : 16'hFFFF;
    endcase
  endfunction

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic run_case(input int d, input bit extra);
    int  t0;
    bit  seen;
    logic [15:0] em;
    load(d);
    clear_mon();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    check_val($sformatf("d%0d busy_on", d), 32'(busy), 32'h3F);
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge clk); #1;
      start = extra && (cyc - t0 == 49);
      if (done[0]) seen = 1'b1;
    end
    start = 1'b0;
    check_val($sformatf("d%0d done_seen", d), 32'(seen), 32'd1);
    check_val($sformatf("d%0d latency", d), 32'(cyc - t0), 32'(LAT));
    check_val($sformatf("d%0d done_all", d), 32'(done), 32'h3F);
    check_val($sformatf("d%0d busy_off", d), 32'(busy), 32'h00);
    for (int k = 0; k < NC; k++) begin
      em = exp_mask(d, k);
      check_val($sformatf("d%0d c%0d mask", d, k), 32'(got_mask[k]), 32'(em));
      check_val($sformatf("d%0d c%0d n_core", d, k), 32'(n_core[k]), 32'($countones(em)));
      check_val($sformatf("d%0d c%0d writes", d, k), 32'(wr_cnt[k]), 32'd16);
      check_val($sformatf("d%0d c%0d order", d, k), 32'(order_err[k]), 32'd0);
    end
    @(posedge clk); #1;
    check_val($sformatf("d%0d done_pulse", d), 32'(done), 32'h00);
    check_val($sformatf("d%0d n_core_hold", d), 32'(n_core[0]), 32'($countones(exp_mask(d, 0))));
  endtask

  initial begin
    int t0;
    int snap;
    bit hit;
    rst = 1'b1; start = 1'b0; mon_clr = 1'b1;
    load(0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst busy", 32'(busy), 32'h00);
    check_val("rst done", 32'(done), 32'h00);
    check_val("rst we", 32'(we_core), 32'h00);
    check_val("rst wcore", 32'(wcore), 32'h00);
    check_val("rst addr", {20'h0, raddr_i[0], raddr_j[0], waddr[0]}, 32'h0);
    check_val("rst n_core", 32'(n_core[0]), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_case(0, 1'b1);
    run_case(1, 1'b0);
    run_case(2, 1'b0);
    run_case(3, 1'b0);

    // asynchronous reset in the middle of a write cycle
    load(0);
    clear_mon();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(posedge clk); #1;
      if (cyc - t0 >= 95 && we_core[0]) hit = 1'b1;
    end
    check_val("mid we seen", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async we drop", 32'(we_core), 32'h00);
    check_val("async busy drop", 32'(busy), 32'h00);
    snap = wr_cnt[0];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_val("no writes after rst", 32'(wr_cnt[0]), 32'(snap));
    check_val("idle after rst", 32'(busy), 32'h00);
    check_val("n_core cleared", 32'(n_core[0]), 32'h0);

    run_case(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
